// File: rtl/wind_pkg.sv
// Shared constants and types for the wind drift integrator.
package wind_pkg;
  localparam int WIND_NEUTRAL = 50;
  localparam int WIND_MAX     = 100;
  localparam int DEADZONE     = 2;

  typedef enum logic [1:0] {IDLE, FLIGHT, HOLD} wind_drift_state_t;

  typedef logic signed [9:0]  vel_t;
  typedef logic signed [15:0] pos_t;
endpackage

// File: rtl/sat_add_s.sv
// Signed adder clamped to the symmetric range [-LIMIT, +LIMIT].
module sat_add_s #(
  parameter int W     = 16,
  parameter int LIMIT = 255
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);
  localparam logic signed [W:0] HI = (W+1)'(LIMIT);
  localparam logic signed [W:0] LO = -HI;

  logic signed [W:0] sum;

  // One extra bit so the raw sum cannot wrap before it is clamped.
  always_comb begin
    sum = {a[W-1], a} + {b[W-1], b};
    if (sum > HI)      y = HI[W-1:0];
    else if (sum < LO) y = LO[W-1:0];
    else               y = sum[W-1:0];
  end
endmodule

// File: rtl/wind_drift.sv
// Latches wind at launch and integrates it into a per-frame x drift.
// Optional near-calm deadzone: define WIND_DRIFT_DEADZONE_EN.
module wind_drift
  import wind_pkg::*;
#(
  parameter int FRAC_BITS  = 4,
  parameter int VEL_MAX    = 255,
  parameter int DRIFT_MAX  = 320,
  parameter int MAX_FRAMES = 600
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         wind,
  input  logic               shot_start,
  input  logic               shot_done,
  input  logic               frame_tick,
  output logic signed [10:0] drift_x,
  output logic               busy,
  output logic               wind_clamped,
  output logic               timeout
);
  localparam logic signed [7:0] NEUTRAL = 8'(WIND_NEUTRAL);
  localparam logic signed [7:0] DZ      = 8'(DEADZONE);

  wind_drift_state_t state;
  vel_t              vel, vel_n, off_ext;
  pos_t              pos, pos_n, vel_ext;
  logic signed [7:0] offset, off_launch;
  logic [6:0]        w_sat;
  logic [15:0]       frames, frames_inc;

  always_comb begin
    w_sat      = (wind > 7'(WIND_MAX)) ? 7'(WIND_MAX) : wind;
    off_launch = $signed({1'b0, w_sat}) - NEUTRAL;
`ifdef WIND_DRIFT_DEADZONE_EN
    if (off_launch >= -DZ && off_launch <= DZ) off_launch = '0;
`endif
  end

  assign off_ext    = vel_t'(offset);
  assign vel_ext    = pos_t'(vel_n);
  assign frames_inc = frames + 16'd1;

  sat_add_s #(.W(10), .LIMIT(VEL_MAX)) u_vel (
    .a(vel), .b(off_ext), .y(vel_n)
  );

  // Position limit is in sub-pixel units so the pixel output saturates at DRIFT_MAX.
  sat_add_s #(.W(16), .LIMIT(DRIFT_MAX << FRAC_BITS)) u_pos (
    .a(pos), .b(vel_ext), .y(pos_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      vel          <= '0;
      pos          <= '0;
      offset       <= '0;
      frames       <= '0;
      drift_x      <= '0;
      busy         <= 1'b0;
      wind_clamped <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE, HOLD: begin
          if (shot_start) begin
            state        <= FLIGHT;
            busy         <= 1'b1;
            vel          <= '0;
            pos          <= '0;
            frames       <= '0;
            drift_x      <= '0;
            offset       <= off_launch;
            wind_clamped <= (wind > 7'(WIND_MAX));
          end
        end
        FLIGHT: begin
          // Landing wins over a coincident frame tick.
          if (shot_done) begin
            state <= HOLD;
            busy  <= 1'b0;
          end else if (frame_tick) begin
            vel     <= vel_n;
            pos     <= pos_n;
            drift_x <= 11'(pos_n >>> FRAC_BITS);
            frames  <= frames_inc;
            if (frames_inc == 16'(MAX_FRAMES)) begin
              state   <= HOLD;
              busy    <= 1'b0;
              timeout <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wind_drift.sv
// Bench for wind_drift: reference model compared every cycle plus literal spot checks.
`timescale 1ns/1ps
module tb_wind_drift;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] wind = '0;
  logic       shot_start = 1'b0, shot_done = 1'b0, frame_tick = 1'b0;

  logic signed [10:0] drift_x [2];
  logic               busy [2], wind_clamped [2], timeout [2];

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  wind_drift dut (
    .clk(clk), .rst(rst), .wind(wind), .shot_start(shot_start),
    .shot_done(shot_done), .frame_tick(frame_tick), .drift_x(drift_x[0]),
    .busy(busy[0]), .wind_clamped(wind_clamped[0]), .timeout(timeout[0])
  );

  wind_drift #(.MAX_FRAMES(5)) dut5 (
    .clk(clk), .rst(rst), .wind(wind), .shot_start(shot_start),
    .shot_done(shot_done), .frame_tick(frame_tick), .drift_x(drift_x[1]),
    .busy(busy[1]), .wind_clamped(wind_clamped[1]), .timeout(timeout[1])
  );

  // Reference model: plain integers, one entry per DUT.
  int m_vel [2], m_pos [2], m_off [2], m_n [2], m_drift [2];
  bit m_fly [2], m_clamp [2], m_to [2];

  function automatic int maxf(input int k);
    return (k == 1) ? 5 : 600;
  endfunction

  function automatic int clampi(input int v, input int lim);
    if (v > lim)  return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  function automatic int floor16(input int v);
    return (v >= 0) ? v / 16 : -((-v + 15) / 16);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_vel[k] <= 0; m_pos[k] <= 0; m_off[k] <= 0; m_n[k] <= 0; m_drift[k] <= 0;
        m_fly[k] <= 0; m_clamp[k] <= 0; m_to[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        automatic int v = m_vel[k], p = m_pos[k], o = m_off[k], n = m_n[k], d = m_drift[k];
        automatic bit f = m_fly[k], c = m_clamp[k], t = 0;
        automatic int w;
        if (!f) begin
          if (shot_start) begin
            w = (int'(wind) > 100) ? 100 : int'(wind);
            o = w - 50;
`ifdef WIND_DRIFT_DEADZONE_EN
            if (o >= -2 && o <= 2) o = 0;
`endif
            c = (int'(wind) > 100);
            v = 0; p = 0; n = 0; d = 0; f = 1;
          end
        end else if (shot_done) begin
          f = 0;
        end else if (frame_tick) begin
          v = clampi(v + o, 255);
          p = clampi(p + v, 320 * 16);
          d = floor16(p);
          n = n + 1;
          if (n == maxf(k)) begin f = 0; t = 1; end
        end
        m_vel[k] <= v; m_pos[k] <= p; m_off[k] <= o; m_n[k] <= n; m_drift[k] <= d;
        m_fly[k] <= f; m_clamp[k] <= c; m_to[k] <= t;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  bit started = 0;
  always @(negedge clk) begin
    if (started && !rst) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("model drift_x[%0d]", k), int'(drift_x[k]), m_drift[k]);
        chk($sformatf("model busy[%0d]", k), int'(busy[k]), int'(m_fly[k]));
        chk($sformatf("model wind_clamped[%0d]", k), int'(wind_clamped[k]), int'(m_clamp[k]));
        chk($sformatf("model timeout[%0d]", k), int'(timeout[k]), int'(m_to[k]));
      end
    end
  end

  task automatic launch(input int w);
    @(negedge clk); wind = 7'(w); shot_start = 1'b1;
    @(negedge clk); shot_start = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
  endtask

  task automatic done();
    @(negedge clk); shot_done = 1'b1;
    @(negedge clk); shot_done = 1'b0;
  endtask

  int exp60 [4] = '{0, 1, 3, 6};
  int exp40 [4] = '{-1, -2, -4, -7};

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    started = 1;
    chk("reset drift_x", int'(drift_x[0]), 0);
    chk("reset busy", int'(busy[0]), 0);
    chk("reset wind_clamped", int'(wind_clamped[0]), 0);
    chk("reset timeout", int'(timeout[0]), 0);

    // Wind 60: positive drift.
    launch(60);
    chk("w60 busy", int'(busy[0]), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("w60 drift tick%0d", i + 1), int'(drift_x[0]), exp60[i]);
      chk("w60 busy", int'(busy[0]), 1);
    end
    done();

    // Wind 40: negative drift floors toward -inf.
    launch(40);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("w40 drift tick%0d", i + 1), int'(drift_x[0]), exp40[i]);
    end
    done();

    // Calm wind: no drift.
    launch(50);
    repeat (100) tick();
    chk("w50 drift", int'(drift_x[0]), 0);
    done();
    chk("w50 busy after done", int'(busy[0]), 0);
    chk("w50 drift held", int'(drift_x[0]), 0);

    // Over-range wind saturates velocity then position.
    launch(127);
    chk("w127 clamped", int'(wind_clamped[0]), 1);
    repeat (40) tick();
    chk("w127 drift sat", int'(drift_x[0]), 320);
    tick();
    chk("w127 drift stays", int'(drift_x[0]), 320);
    done();
    chk("w127 clamped held", int'(wind_clamped[0]), 1);

    // shot_done coincident with frame_tick: tick dropped, state HOLD.
    launch(60);
    chk("relaunch clamped cleared", int'(wind_clamped[0]), 0);
    tick(); tick();
    @(negedge clk); shot_done = 1'b1; frame_tick = 1'b1;
    @(negedge clk); shot_done = 1'b0; frame_tick = 1'b0;
    chk("done+tick drift", int'(drift_x[0]), 1);
    chk("done+tick busy", int'(busy[0]), 0);
    tick();
    chk("hold ignores tick", int'(drift_x[0]), 1);

    // shot_start + frame_tick in HOLD; shot_start mid-flight ignored.
    @(negedge clk); wind = 7'd60; shot_start = 1'b1; frame_tick = 1'b1;
    @(negedge clk); shot_start = 1'b0; frame_tick = 1'b0;
    chk("start+tick drift", int'(drift_x[0]), 0);
    chk("start+tick busy", int'(busy[0]), 1);
    tick();
    chk("start+tick first", int'(drift_x[0]), 0);
    launch(0);
    tick();
    chk("midflight start ignored", int'(drift_x[0]), 1);
    done();

    // MAX_FRAMES = 5 instance: timeout on the 5th tick.
    launch(60);
    repeat (4) tick();
    chk("t5 busy before", int'(busy[1]), 1);
    tick();
    chk("t5 timeout pulse", int'(timeout[1]), 1);
    chk("t5 busy falls", int'(busy[1]), 0);
    chk("t5 drift", int'(drift_x[1]), 9);
    @(negedge clk);
    chk("t5 timeout one cycle", int'(timeout[1]), 0);
    done();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      wind       = 7'($urandom_range(0, 127));
      shot_start = ($urandom_range(0, 39) == 0);
      shot_done  = ($urandom_range(0, 59) == 0);
      frame_tick = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    shot_start = 1'b0; shot_done = 1'b0; frame_tick = 1'b0;
    done();

    // Full-length flight times out at 600 frames.
    launch(70);
    @(negedge clk); frame_tick = 1'b1;
    repeat (599) @(negedge clk);
    chk("t600 busy before", int'(busy[0]), 1);
    @(negedge clk); frame_tick = 1'b0;
    chk("t600 timeout", int'(timeout[0]), 1);
    chk("t600 busy", int'(busy[0]), 0);
    chk("t600 drift sat", int'(drift_x[0]), 320);

    // Asynchronous reset mid-flight.
    launch(80);
    repeat (3) tick();
    chk("pre-reset busy", int'(busy[0]), 1);
    #2 rst = 1'b1;
    #1;
    chk("async rst drift", int'(drift_x[0]), 0);
    chk("async rst busy", int'(busy[0]), 0);
    chk("async rst clamped", int'(wind_clamped[1]), 0);
    chk("async rst busy5", int'(busy[1]), 0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
